// File: rtl/color_config_arbiter.sv
// Configuration-bus sequencer: replays boot defaults after reset, then arbitrates
// two requesters round-robin, optionally only during vertical blanking.
module color_config_arbiter #(
  parameter int unsigned                            C_ADDR_WIDTH  = 8,
  parameter int unsigned                            C_DATA_WIDTH  = 16,
  parameter int unsigned                            DEFAULT_COUNT = 4,
  parameter logic [DEFAULT_COUNT*C_DATA_WIDTH-1:0] DEFAULT_INIT  = '0,
  parameter bit                                     BLANK_GATE    = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    V_Blank,
  input  logic [C_ADDR_WIDTH-1:0] Req0_Addr,
  input  logic [C_DATA_WIDTH-1:0] Req0_Data,
  input  logic                    Req0_Valid,
  output logic                    Req0_Rdy,
  input  logic [C_ADDR_WIDTH-1:0] Req1_Addr,
  input  logic [C_DATA_WIDTH-1:0] Req1_Data,
  input  logic                    Req1_Valid,
  output logic                    Req1_Rdy,
  output logic [C_ADDR_WIDTH-1:0] C_Addr,
  output logic [C_DATA_WIDTH-1:0] C_Data,
  output logic                    C_Valid,
  input  logic                    C_Rdy,
  output logic [1:0]              Grant,
  output logic                    Boot_Done
);

  localparam logic [C_ADDR_WIDTH-1:0] LAST_IDX = C_ADDR_WIDTH'(DEFAULT_COUNT - 1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_IDLE  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic [1:0]              grant_q, grant_d;
  logic                    done_q, done_d;
  logic                    last_q, last_d;   // 1 = port 1 was granted last

  logic                    gate_open_c;
  logic                    accept_c;
  logic                    sel1_c;
  logic [C_ADDR_WIDTH-1:0] idx_inc_c;

  // Boot word lookup by index, written as a compare loop to keep slicing in range.
  function automatic logic [C_DATA_WIDTH-1:0] boot_word(input logic [C_ADDR_WIDTH-1:0] idx);
    boot_word = '0;
    for (int unsigned k = 0; k < DEFAULT_COUNT; k++) begin
      if (idx == C_ADDR_WIDTH'(k)) begin
        boot_word = DEFAULT_INIT[k*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
    end
  endfunction

  assign gate_open_c = V_Blank | ~BLANK_GATE;
  assign accept_c    = (state_q == S_IDLE) & gate_open_c & (Req0_Valid | Req1_Valid);
  // Port 1 wins when alone, or when both are pending and port 0 had the last grant.
  assign sel1_c      = Req1_Valid & (~Req0_Valid | ~last_q);
  assign idx_inc_c   = idx_q + C_ADDR_WIDTH'(1);

  assign Req0_Rdy = accept_c & ~sel1_c;
  assign Req1_Rdy = accept_c &  sel1_c;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    done_d  = done_q;
    last_d  = last_q;

    case (state_q)
      S_BOOT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = idx_q;
          data_d  = boot_word(idx_q);
        end else if (C_Rdy) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_inc_c;
            addr_d = idx_inc_c;
            data_d = boot_word(idx_inc_c);
          end
        end
      end

      S_IDLE: begin
        if (accept_c) begin
          valid_d = 1'b1;
          state_d = S_WRITE;
          if (sel1_c) begin
            addr_d  = Req1_Addr;
            data_d  = Req1_Data;
            grant_d = 2'b10;
            last_d  = 1'b1;
          end else begin
            addr_d  = Req0_Addr;
            data_d  = Req0_Data;
            grant_d = 2'b01;
            last_d  = 1'b0;
          end
        end
      end

      S_WRITE: begin
        if (C_Rdy) begin
          valid_d = 1'b0;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_BOOT;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= 2'b00;
      done_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign C_Addr    = addr_q;
  assign C_Data    = data_q;
  assign C_Valid   = valid_q;
  assign Grant     = grant_q;
  assign Boot_Done = done_q;

endmodule

// File: tb/tb_color_config_arbiter.sv
// Self-checking bench for color_config_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_color_config_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned CNT = 4;
  localparam logic [CNT*DW-1:0] INIT = 64'h0D0D_0C0C_0B0B_0A0A;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          V_Blank;
  logic [AW-1:0] Req0_Addr, Req1_Addr;
  logic [DW-1:0] Req0_Data, Req1_Data;
  logic          Req0_Valid, Req1_Valid;
  logic          Req0_Rdy, Req1_Rdy;
  logic [AW-1:0] C_Addr;
  logic [DW-1:0] C_Data;
  logic          C_Valid;
  logic          C_Rdy;
  logic [1:0]    Grant;
  logic          Boot_Done;

  always #5 Clk = ~Clk;

  color_config_arbiter #(
    .C_ADDR_WIDTH (AW),
    .C_DATA_WIDTH (DW),
    .DEFAULT_COUNT(CNT),
    .DEFAULT_INIT (INIT),
    .BLANK_GATE   (1'b1)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .V_Blank   (V_Blank),
    .Req0_Addr (Req0_Addr),
    .Req0_Data (Req0_Data),
    .Req0_Valid(Req0_Valid),
    .Req0_Rdy  (Req0_Rdy),
    .Req1_Addr (Req1_Addr),
    .Req1_Data (Req1_Data),
    .Req1_Valid(Req1_Valid),
    .Req1_Rdy  (Req1_Rdy),
    .C_Addr    (C_Addr),
    .C_Data    (C_Data),
    .C_Valid   (C_Valid),
    .C_Rdy     (C_Rdy),
    .Grant     (Grant),
    .Boot_Done (Boot_Done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: boot words as a queue of pending writes, then a single
  // bus slot that is either empty or owned by one requester.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           boot_q[$];
  bit            m_done, m_on;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_owner;   // 0 none/boot, 1 port0, 2 port1
  int            m_last;    // last granted port
  int            m_pick;    // port accepted this cycle, -1 if none

  // Samples of DUT outputs taken in the most recent step
  logic          s_rdy0, s_rdy1, s_cvalid;
  logic [1:0]    s_grant;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [AW-1:0] xfer_q[$];

  task automatic model_reset();
    wr_t w;
    boot_q.delete();
    for (int k = 0; k < int'(CNT); k++) begin
      w.a = AW'(k);
      w.d = DW'(16'h0A0A + k * 16'h0101);
      boot_q.push_back(w);
    end
    m_done  = 1'b0;
    m_on    = 1'b0;
    m_owner = 0;
    m_last  = 1;
  endtask

  // One clock cycle: called at a falling edge, drives, checks, advances model.
  task automatic step(input bit vb, input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input bit crdy);
    logic [1:0] eg;
    V_Blank = vb; Req0_Valid = v0; Req0_Addr = a0; Req0_Data = d0;
    Req1_Valid = v1; Req1_Addr = a1; Req1_Data = d1; C_Rdy = crdy;
    #1;
    m_pick = -1;
    if (m_done && !m_on && vb) begin
      if (v0 && v1)  m_pick = (m_last == 0) ? 1 : 0;
      else if (v0)   m_pick = 0;
      else if (v1)   m_pick = 1;
    end
    eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    s_rdy0 = Req0_Rdy; s_rdy1 = Req1_Rdy; s_cvalid = C_Valid;
    s_grant = Grant; s_addr = C_Addr; s_data = C_Data;
    chk("c_valid",   32'(C_Valid),   32'(m_on));
    chk("grant",     32'(Grant),     32'(eg));
    chk("boot_done", 32'(Boot_Done), 32'(m_done));
    chk("req0_rdy",  32'(Req0_Rdy),  32'(m_pick == 0));
    chk("req1_rdy",  32'(Req1_Rdy),  32'(m_pick == 1));
    if (m_on) begin
      chk("c_addr", 32'(C_Addr), 32'(m_addr));
      chk("c_data", 32'(C_Data), 32'(m_data));
    end
    if (C_Valid && crdy) xfer_q.push_back(C_Addr);

    if (!m_done) begin
      if (m_on && crdy) begin
        void'(boot_q.pop_front());
        if (boot_q.size() == 0) begin
          m_on = 1'b0;
          m_done = 1'b1;
        end else begin
          m_addr = boot_q[0].a;
          m_data = boot_q[0].d;
        end
      end else if (!m_on) begin
        m_on = 1'b1;
        m_addr = boot_q[0].a;
        m_data = boot_q[0].d;
      end
    end else if (m_on) begin
      if (crdy) begin
        m_on = 1'b0;
        m_owner = 0;
      end
    end else if (m_pick >= 0) begin
      m_on    = 1'b1;
      m_owner = m_pick + 1;
      m_last  = m_pick;
      m_addr  = (m_pick == 0) ? a0 : a1;
      m_data  = (m_pick == 0) ? d0 : d1;
    end
    @(negedge Clk);
  endtask

  task automatic idle_step(input bit crdy);
    step(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, crdy);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    Rst = 1'b0;
    #1;
    chk("rst_c_valid",   32'(C_Valid),   32'(0));
    chk("rst_grant",     32'(Grant),     32'(0));
    chk("rst_boot_done", 32'(Boot_Done), 32'(0));
    chk("rst_req0_rdy",  32'(Req0_Rdy),  32'(0));
    chk("rst_req1_rdy",  32'(Req1_Rdy),  32'(0));
    model_reset();
    Req0_Valid = 1'b0;
    Req1_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  typedef struct {
    bit vb, v0, v1, crdy;
    bit r0, r1, cv;
    logic [1:0] g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int  n0, n1, gi;
    bit  pend0, pend1, vb;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    logic [1:0] gexp[4];

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'h10, 16'h1234};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 8'h10, 16'h1234};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 8'h10, 16'h1234};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 8'h20, 16'h5678};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 8'h10, 16'h1234};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 8'h20, 16'h5678};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 16'h0000};

    Rst = 1'b0; V_Blank = 1'b0; C_Rdy = 1'b0;
    Req0_Valid = 1'b0; Req0_Addr = '0; Req0_Data = '0;
    Req1_Valid = 1'b0; Req1_Addr = '0; Req1_Data = '0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    chk("por_c_valid",   32'(C_Valid),   32'(0));
    chk("por_grant",     32'(Grant),     32'(0));
    chk("por_boot_done", 32'(Boot_Done), 32'(0));
    chk("por_c_addr",    32'(C_Addr),    32'(0));
    Rst = 1'b1;

    // Boot with sink always ready: four back-to-back writes
    xfer_q.delete();
    idle_step(1'b1);
    chk("boot_first_valid_pre", 32'(s_cvalid), 32'(0));
    idle_step(1'b1);
    chk("boot_first_valid", 32'(s_cvalid), 32'(1));
    chk("boot_first_addr",  32'(s_addr),   32'(0));
    chk("boot_first_data",  32'(s_data),   32'(16'h0A0A));
    for (int i = 0; i < 4; i++) idle_step(1'b1);
    chk("boot_xfer_count", 32'(xfer_q.size()), 32'(4));
    for (int i = 0; i < 4 && i < xfer_q.size(); i++) chk("boot_xfer_addr", 32'(xfer_q[i]), 32'(i));
    chk("boot_done_end",  32'(Boot_Done), 32'(1));
    chk("boot_valid_end", 32'(C_Valid),   32'(0));

    // Boot stall at index 1
    do_reset();
    xfer_q.delete();
    idle_step(1'b1);
    idle_step(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle_step(1'b0);
      chk("stall_addr", 32'(s_addr), 32'(1));
      chk("stall_data", 32'(s_data), 32'(16'h0B0B));
    end
    for (int i = 0; i < 4; i++) idle_step(1'b1);
    chk("stall_xfer_count", 32'(xfer_q.size()), 32'(4));
    for (int i = 0; i < 4 && i < xfer_q.size(); i++) chk("stall_xfer_addr", 32'(xfer_q[i]), 32'(i));
    chk("stall_boot_done", 32'(Boot_Done), 32'(1));

    // Gating, mid-write gate close and round-robin from the vector table
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].vb, tbl[i].v0, 8'h10, 16'h1234, tbl[i].v1, 8'h20, 16'h5678, tbl[i].crdy);
      chk($sformatf("tbl%0d_rdy0", i),  32'(s_rdy0),   32'(tbl[i].r0));
      chk($sformatf("tbl%0d_rdy1", i),  32'(s_rdy1),   32'(tbl[i].r1));
      chk($sformatf("tbl%0d_valid", i), 32'(s_cvalid), 32'(tbl[i].cv));
      chk($sformatf("tbl%0d_grant", i), 32'(s_grant),  32'(tbl[i].g));
      if (tbl[i].cv) begin
        chk($sformatf("tbl%0d_addr", i), 32'(s_addr), 32'(tbl[i].a));
        chk($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].d));
      end
    end

    // Continuous contention after a fresh reset: port 0 goes first
    do_reset();
    for (int i = 0; i < 6; i++) idle_step(1'b1);
    gexp[0] = 2'b01; gexp[1] = 2'b10; gexp[2] = 2'b01; gexp[3] = 2'b10;
    n0 = 0; n1 = 0; gi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 8'h31, 16'hAAAA, 1'b1, 8'h42, 16'hBBBB, 1'b1);
      if (s_rdy0) n0++;
      if (s_rdy1) n1++;
      if (s_cvalid) begin
        if (gi < 4) chk("rr_grant", 32'(s_grant), 32'(gexp[gi]));
        gi++;
      end
    end
    chk("rr_writes",    32'(gi), 32'(4));
    chk("rr_rdy0_count", 32'(n0), 32'(2));
    chk("rr_rdy1_count", 32'(n1), 32'(2));

    // Reset while a requester write is stalled on the bus
    step(1'b1, 1'b1, 8'h55, 16'hCAFE, 1'b0, 8'h00, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 8'h56, 16'hBEEF, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk("rmw_in_write", 32'(s_cvalid), 32'(1));
    Req0_Valid = 1'b1;
    do_reset();
    idle_step(1'b1);
    idle_step(1'b1);
    chk("rmw_reboot_valid", 32'(s_cvalid), 32'(1));
    chk("rmw_reboot_addr",  32'(s_addr),   32'(0));
    chk("rmw_reboot_data",  32'(s_data),   32'(16'h0A0A));

    // Randomized traffic with occasional resets
    pend0 = 1'b0; pend1 = 1'b0; vb = 1'b0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        pend0 = 1'b0;
        pend1 = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) vb = ~vb;
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; pa0 = AW'($urandom); pd0 = DW'($urandom);
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; pa1 = AW'($urandom); pd1 = DW'($urandom);
      end
      step(vb, pend0, pa0, pd0, pend1, pa1, pd1, $urandom_range(0, 9) < 7);
      if (m_pick == 0) pend0 = 1'b0;
      if (m_pick == 1) pend1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/color_config_arbiter.md
# color_config_arbiter

Sequencer and arbiter for the color manager's configuration write bus (C_Addr/C_Data/C_Valid/C_Rdy). After reset it writes a fixed set of default configuration words. It then shares the bus round-robin between two requesters: the UART configuration path (port 0) and the debug/overlay path (port 1). Optionally, it opens the bus to requesters only during vertical blanking, so palette and porch changes never tear a visible frame.

## Interface
- C_ADDR_WIDTH, 8, config address width
- C_DATA_WIDTH, 16, config data width
- DEFAULT_COUNT, 4, number of boot writes (1..2^C_ADDR_WIDTH)
- DEFAULT_INIT, 0, packed boot data; word k = DEFAULT_INIT[k*C_DATA_WIDTH +: C_DATA_WIDTH]
- BLANK_GATE, 1, 1 = requesters granted only while V_Blank=1; 0 = always
- Clk  input  1  single clock, rising edge
- Rst  input  1  reset, asynchronous, active-low (0 = reset)
- V_Blank  input  1  1 = vertical blanking interval
- Req0_Addr / Req0_Data  input  C_ADDR_WIDTH / C_DATA_WIDTH  port 0 write request
- Req0_Valid  input  1  port 0 request pending; held until Req0_Rdy
- Req0_Rdy  output  1  port 0 request accepted this cycle (combinational)
- Req1_Addr / Req1_Data / Req1_Valid / Req1_Rdy  same as port 0, for port 1
- C_Addr  output  C_ADDR_WIDTH  config bus address (registered)
- C_Data  output  C_DATA_WIDTH  config bus data (registered)
- C_Valid  output  1  config bus write valid (registered)
- C_Rdy  input  1  config bus sink ready; a write transfers when C_Valid & C_Rdy
- Grant  output  2  one-hot owner of the current bus write: bit0 = port 0, bit1 = port 1, 00 = boot or idle
- Boot_Done  output  1  1 once all boot writes have transferred

## Operation
- States: BOOT, IDLE, WRITE.
- Reset (Rst=0) forces state BOOT, boot index 0, Last_Grant = port 1, and all outputs 0. This applies mid-operation too: an in-flight write is dropped and boot restarts.
- BOOT behaviour:
  - Drives C_Valid=1, C_Addr = index (zero-extended), C_Data = DEFAULT_INIT word[index].
  - Each handshake increments index; addr/data update on the same edge and C_Valid stays 1, so boot writes run back-to-back.
  - After the handshake at index DEFAULT_COUNT-1: C_Valid←0, Boot_Done←1, state←IDLE.
  - Ignores V_Blank. Req0_Rdy = Req1_Rdy = 0 throughout.
- Gate_Open = V_Blank | ~BLANK_GATE.
- IDLE with Gate_Open and at least one ReqN_Valid:
  - Selection: if only one port is valid, it is selected. If both are valid, the port ≠ Last_Grant is selected (round-robin).
  - ReqN_Rdy = 1 combinationally for the selected port only.
  - On that edge: C_Addr/C_Data ← ReqN_Addr/ReqN_Data, C_Valid←1, Grant←one-hot N, Last_Grant←N, state←WRITE.
- IDLE with gate closed or no request: outputs hold, C_Valid=0, Grant=00.
- WRITE:
  - C_Valid, C_Addr, C_Data and Grant hold until C_Rdy=1.
  - On the handshake edge: C_Valid←0, Grant←00, state←IDLE.
  - V_Blank falling during WRITE does not abort; the write completes.
- Requester valids are ignored outside IDLE; a pending request waits.
- Boot_Done stays 1 until the next reset.

## Timing
- Reset release to first boot C_Valid: C_Valid=1 on the first rising edge after Rst goes high.
- Boot with C_Rdy held 1: DEFAULT_COUNT consecutive cycles of C_Valid. Boot_Done=1 and C_Valid=0 from the next cycle.
- Request acceptance: ReqN_Rdy pulses in cycle t (IDLE, gate open); C_Valid=1 from cycle t+1.
- Minimum one cycle with C_Valid=0 between requester writes, giving at most one requester write per 2 cycles.
- C_Rdy stalls of any length hold all bus outputs stable.
- V_Blank is sampled only in IDLE, combinationally, in the acceptance cycle.

## Test plan
- Boot sequence: DEFAULT_COUNT=4, DEFAULT_INIT={16'h0D0D,16'h0C0C,16'h0B0B,16'h0A0A}, C_Rdy=1.
  - Required: writes (0,0A0A),(1,0B0B),(2,0C0C),(3,0D0D) on 4 consecutive cycles.
  - Then Boot_Done=1 and C_Valid=0.
- Boot stall: C_Rdy=0 for 3 cycles at index 1.
  - Required: C_Addr=1, C_Data=0B0B held for those 3 cycles.
  - Then the sequence continues; no address is skipped or repeated.
- Blank gating: BLANK_GATE=1, V_Blank=0, Req0_Valid with (8'h10,16'h1234).
  - Required: Req0_Rdy=0 and C_Valid=0 while V_Blank=0.
  - After V_Blank←1: Req0_Rdy pulses, and the next cycle shows C_Addr=10, C_Data=1234, Grant=01.
- Round-robin: both ports valid continuously, V_Blank=1, C_Rdy=1.
  - Required: Grant alternates 01,10,01,10 (port 0 first after reset).
  - Each port's Rdy pulses once per 4 cycles.
- Gate closes mid-write: write in WRITE with C_Rdy=0, V_Blank←0, then C_Rdy←1 two cycles later.
  - Required: the write transfers with data unchanged.
  - No new grant while V_Blank=0.
- Reset mid-write: Rst←0 during WRITE.
  - Required: C_Valid, Grant, Boot_Done and both Rdy are 0 immediately (asynchronously).
  - After release, boot restarts at address 0.
